pulse_width_meter: RTL

Parametrised, handshaked pulse-width measurement block: counts the clock cycles for which a (optionally synchronised) input stays at its active level and delivers each completed width as one record on a valid/ready output port. It extends the single-channel 8-bit pulse-duration counter with:
- configurable counter width and pulse polarity;
- saturation with a flag;
- overrun detection;
- compile-time min/max tracking.

It sits between asynchronous sensor/timing inputs and the measurement/readout logic.

---
 rtl/pulse_width_meter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pulse_width_meter.sv
// Pulse-width meter: counts active cycles of a synchronised input and emits one record per pulse; optional min/max via PULSE_MINMAX_EN.
// Latency: record valid SYNC_STAGES edges after the first inactive sample of signal_in.
// Backpressure: single-entry output; a capture while the held record is stalled is dropped and sets sticky overrun.
module pulse_width_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int POLARITY    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             signal_in,
    output logic [CNT_W-1:0] dur_data,
    output logic             dur_sat,
    output logic             dur_valid,
    input  logic             dur_ready,
    output logic             overrun,
    input  logic             clear_flags
`ifdef PULSE_MINMAX_EN
    ,
    output logic [CNT_W-1:0] min_dur,
    output logic [CNT_W-1:0] max_dur
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic             ACT_LVL = (POLARITY != 0);

    typedef enum logic [1:0] {ARM, IDLE, COUNT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic             s;
    logic             act;
    logic             capture;
    logic             load;
    logic             drop;

    // Synchroniser resets to the active level so a pulse straddling reset release is never measured.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = signal_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= {SYNC_STAGES{ACT_LVL}};
                end else begin
                    sync_q[0] <= signal_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign act = (s == ACT_LVL);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ARM:   if (!act) state_d = IDLE;
            IDLE:  if (act) state_d = COUNT;
            COUNT: begin
                if (!act) begin
                    state_d = IDLE;
                    capture = 1'b1;
                end
            end
            default: state_d = ARM;
        endcase
        if (!enable) begin
            state_d = ARM;
            capture = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARM;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (enable && act && state_q == IDLE) begin
                cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
                sat_q <= 1'b0;
            end else if (enable && act && state_q == COUNT) begin
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                sat_q <= sat_q | (cnt_q == CNT_MAX - 1'b1);
            end
        end
    end

    // A handshake in the same cycle frees the slot, so the new record may load.
    assign load = capture & (~dur_valid | dur_ready);
    assign drop = capture & dur_valid & ~dur_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            dur_data  <= '0;
            dur_sat   <= 1'b0;
            dur_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                dur_data  <= cnt_q;
                dur_sat   <= sat_q;
                dur_valid <= 1'b1;
            end else if (dur_ready) begin
                dur_valid <= 1'b0;
            end
            if (drop) overrun <= 1'b1;
            else if (clear_flags) overrun <= 1'b0;
        end
    end

`ifdef PULSE_MINMAX_EN
    // Tracks every completed pulse, including those dropped by overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            min_dur <= CNT_MAX;
            max_dur <= '0;
        end else if (clear_flags) begin
            min_dur <= capture ? cnt_q : CNT_MAX;
            max_dur <= capture ? cnt_q : '0;
        end else if (capture) begin
            if (cnt_q < min_dur) min_dur <= cnt_q;
            if (cnt_q > max_dur) max_dur <= cnt_q;
        end
    end
`endif

endmodule
